mem_arb_ctrl_32_12: RTL and testbench



---
 rtl/mem_arb_ctrl_32_12_pkg.sv | 16 +
 rtl/mem_arb_ctrl_32_12_if.sv | 26 ++
 rtl/mem_arb_ctrl_32_12_rr_arb2.sv | 40 ++++
 rtl/mem_arb_ctrl_32_12.sv | 159 +++++++++++++++
 tb/tb_mem_arb_ctrl_32_12.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_ctrl_32_12_pkg.sv
// Shared constants and types for the two-port SRAM front-end controller.
package mem_arb_pkg;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 12;
    localparam int MEM_DEPTH = 4096;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;
endpackage

// File: rtl/mem_arb_ctrl_32_12_if.sv
// Requester ports and SRAM macro pins of the controller, bundled as one bus.
interface mem_arb_ctrl_32_12_if;
    import mem_arb_pkg::*;

    logic              req0, we0, gnt0, rvalid0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, we1, gnt1, rvalid1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic              mem_chip_en, mem_rd_en, mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd_data,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  mem_chip_en, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rd_data,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output mem_chip_en, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/mem_arb_ctrl_32_12_rr_arb2.sv
// Two-way round-robin arbiter: on contention the port not granted last wins.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_q, last_d;

    // Grant decode; last_q holds the most recently granted port.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves only when a grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Reset to "port 1 was last" so port 0 is preferred first.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mem_arb_ctrl_32_12.sv
// SRAM front end: zero-fill after reset, then round-robin sharing between two
// requesters with registered memory commands and fixed-latency read return.
module mem_arb_ctrl_32_12
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter bit INIT_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    output logic                init_done,
    mem_arb_ctrl_32_12_if.slave bus
);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(MEM_DEPTH - 1);
    localparam state_e          RST_STATE = INIT_EN ? ST_INIT : ST_SERVE;

    state_e             state_q, state_d;
    logic [ADDR_W:0]    init_cnt_q, init_cnt_d;
    logic               chip_en_q, chip_en_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    rd_tag_t [RD_LAT:0] tag_q, tag_d;
    rd_tag_t            push_tag_s, tag_out_s;
    logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic               serve_s, advance_s;
    logic [1:0]         arb_req_s, arb_gnt_s;

    assign serve_s   = (state_q == ST_SERVE) && !reset;
    assign arb_req_s = serve_s ? {bus.req1, bus.req0} : 2'b00;
    assign advance_s = |arb_gnt_s;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (arb_req_s),
        .advance (advance_s),
        .gnt     (arb_gnt_s)
    );

    assign init_done       = serve_s;
    assign bus.gnt0        = arb_gnt_s[0];
    assign bus.gnt1        = arb_gnt_s[1];
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.mem_chip_en = chip_en_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;

    // FSM and next memory command: sweep writes during INIT, winner's access in SERVE.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        chip_en_d  = 1'b0;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        push_tag_s = '0;
        case (state_q)
            ST_INIT: begin
                chip_en_d  = 1'b1;
                wr_en_d    = 1'b1;
                addr_d     = init_cnt_q[ADDR_W-1:0];
                wdata_d    = '0;
                init_cnt_d = init_cnt_q + (ADDR_W + 1)'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_SERVE: begin
                state_d = ST_SERVE;
                if (arb_gnt_s[0]) begin
                    chip_en_d  = 1'b1;
                    wr_en_d    = bus.we0;
                    rd_en_d    = !bus.we0;
                    addr_d     = bus.addr0;
                    wdata_d    = bus.wdata0;
                    push_tag_s = '{valid: !bus.we0, port: 1'b0};
                end else if (arb_gnt_s[1]) begin
                    chip_en_d  = 1'b1;
                    wr_en_d    = bus.we1;
                    rd_en_d    = !bus.we1;
                    addr_d     = bus.addr1;
                    wdata_d    = bus.wdata1;
                    push_tag_s = '{valid: !bus.we1, port: 1'b1};
                end else begin
                    chip_en_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Tag shift register aligns the port id with mem_rd_data RD_LAT cycles later.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = push_tag_s;
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Steer returning read data to the tagged port; data holds between pulses.
    always_comb begin
        tag_out_s = tag_q[RD_LAT];
        rvalid0_d = tag_out_s.valid && !tag_out_s.port;
        rvalid1_d = tag_out_s.valid && tag_out_s.port;
        if (rvalid0_d) begin
            rdata0_d = bus.mem_rd_data;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rvalid1_d) begin
            rdata1_d = bus.mem_rd_data;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State registers; reset also flushes in-flight read tags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RST_STATE;
            init_cnt_q <= '0;
            chip_en_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_q      <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            chip_en_q  <= chip_en_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tag_q      <= tag_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_mem_arb_ctrl_32_12.sv
// Bench: random and directed traffic on two requesters, checked against a
// transaction-level model (shadow memory, grant rules, response schedule).
module tb_mem_arb_ctrl_32_12;
    import mem_arb_pkg::*;

    typedef struct {
        bit                idle;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct {
        bit                port;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset_b = 1'b1;
    logic init_done, init_done_b;
    bit   mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clock = ~clock;

    mem_arb_ctrl_32_12_if bus ();
    mem_arb_ctrl_32_12_if bus_b ();

    mem_arb_ctrl_32_12 #(.RD_LAT(1), .INIT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .init_done(init_done), .bus(bus));
    mem_arb_ctrl_32_12 #(.RD_LAT(1), .INIT_EN(1'b0)) dut_b (
        .clock(clock), .reset(reset_b), .init_done(init_done_b), .bus(bus_b));

    assign bus_b.mem_rd_data = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input bit idle, input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data);
        cmd_t c;
        c.idle = idle; c.we = we; c.addr = addr; c.data = data;
        return c;
    endfunction

    // SRAM model with one cycle read latency; contents start as random garbage.
    logic [DATA_W-1:0] sram [MEM_DEPTH];
    bit sram_filled = 1'b0;
    always @(posedge clock) begin
        if (!sram_filled) begin
            for (int i = 0; i < MEM_DEPTH; i++) sram[i] <= $urandom;
            sram_filled <= 1'b1;
        end else if (bus.mem_chip_en) begin
            if (bus.mem_wr_en) sram[bus.mem_addr] <= bus.mem_wr_data;
            if (bus.mem_rd_en) bus.mem_rd_data <= sram[bus.mem_addr];
        end
    end

    // Per-port drivers: hold the queue head until granted; idle entries burn a cycle.
    cmd_t q0[$], q1[$];
    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        forever begin
            @(posedge clock); #1;
            if (q0.size() != 0 && q0[0].idle) begin
                bus.req0 = 1'b0; q0.delete(0);
            end else if (q0.size() != 0) begin
                bus.req0 = 1'b1; bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].data;
            end else bus.req0 = 1'b0;
            @(negedge clock);
            if (bus.req0 && bus.gnt0) q0.delete(0);
        end
    end
    initial begin
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        forever begin
            @(posedge clock); #1;
            if (q1.size() != 0 && q1[0].idle) begin
                bus.req1 = 1'b0; q1.delete(0);
            end else if (q1.size() != 0) begin
                bus.req1 = 1'b1; bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].data;
            end else bus.req1 = 1'b0;
            @(negedge clock);
            if (bus.req1 && bus.gnt1) q1.delete(0);
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] shadow [MEM_DEPTH];
    rsp_t              exp_q[$];
    bit                gnt_log[$];
    bit                m_last = 1'b1, m_prev_reset = 1'b1, m_prev_gnt = 1'b0, m_prev_we = 1'b0;
    logic [ADDR_W-1:0] m_prev_addr = '0;
    logic [DATA_W-1:0] m_prev_data = '0, m_rdata0 = '0, m_rdata1 = '0;
    int                m_init_left = MEM_DEPTH, m_prev_init = -1;

    always @(negedge clock) begin : model
        bit e_g0, e_g1, e_rv0, e_rv1;
        if (mon_en) begin
            cyc++;
            if (m_prev_reset) begin
                check_val("rst_chip_en", 32'(bus.mem_chip_en), 32'd0);
                check_val("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
                check_val("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
                check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
                check_val("rst_wdata", bus.mem_wr_data, 32'd0);
            end else if (m_prev_init >= 0) begin
                check_val("init_chip_en", 32'(bus.mem_chip_en), 32'd1);
                check_val("init_wr_en", 32'(bus.mem_wr_en), 32'd1);
                check_val("init_rd_en", 32'(bus.mem_rd_en), 32'd0);
                check_val("init_addr", 32'(bus.mem_addr), m_prev_init);
                check_val("init_wdata", bus.mem_wr_data, 32'd0);
            end else begin
                check_val("cmd_chip_en", 32'(bus.mem_chip_en), 32'(m_prev_gnt));
                check_val("cmd_wr_en", 32'(bus.mem_wr_en), 32'(m_prev_gnt && m_prev_we));
                check_val("cmd_rd_en", 32'(bus.mem_rd_en), 32'(m_prev_gnt && !m_prev_we));
                if (m_prev_gnt) begin
                    check_val("cmd_addr", 32'(bus.mem_addr), 32'(m_prev_addr));
                    if (m_prev_we) check_val("cmd_wdata", bus.mem_wr_data, m_prev_data);
                end
            end
            e_rv0 = 1'b0; e_rv1 = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                if (exp_q[0].port) begin e_rv1 = 1'b1; m_rdata1 = exp_q[0].data; end
                else begin e_rv0 = 1'b1; m_rdata0 = exp_q[0].data; end
                exp_q.delete(0);
            end
            check_val("rvalid0", 32'(bus.rvalid0), 32'(e_rv0));
            check_val("rvalid1", 32'(bus.rvalid1), 32'(e_rv1));
            check_val("rdata0", bus.rdata0, m_rdata0);
            check_val("rdata1", bus.rdata1, m_rdata1);
            e_g0 = 1'b0; e_g1 = 1'b0;
            if (!reset && m_init_left == 0) begin
                if (bus.req0 && bus.req1) begin
                    e_g0 = m_last; e_g1 = !m_last;
                end else begin
                    e_g0 = bus.req0; e_g1 = bus.req1;
                end
            end
            check_val("init_done", 32'(init_done), 32'(!reset && m_init_left == 0));
            check_val("gnt0", 32'(bus.gnt0), 32'(e_g0));
            check_val("gnt1", 32'(bus.gnt1), 32'(e_g1));
            m_prev_reset = reset; m_prev_init = -1; m_prev_gnt = 1'b0;
            if (reset) begin
                m_last = 1'b1; exp_q.delete(); m_init_left = MEM_DEPTH;
                m_rdata0 = '0; m_rdata1 = '0;
                for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = '0;
            end else if (m_init_left != 0) begin
                m_prev_init = MEM_DEPTH - m_init_left;
                m_init_left--;
            end else if (e_g0 || e_g1) begin
                m_prev_gnt  = 1'b1;
                m_prev_we   = e_g1 ? bus.we1 : bus.we0;
                m_prev_addr = e_g1 ? bus.addr1 : bus.addr0;
                m_prev_data = e_g1 ? bus.wdata1 : bus.wdata0;
                m_last = e_g1;
                gnt_log.push_back(e_g1);
                if (m_prev_we) shadow[m_prev_addr] = m_prev_data;
                else exp_q.push_back('{port: e_g1, data: shadow[m_prev_addr], due: cyc + 3});
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || m_init_left != 0) && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (n >= budget) check_val("drain_timeout", 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
        repeat (2) @(posedge clock);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit exp_seq[8];
        bit got;
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 12'h055; bus_b.wdata0 = '0;
        bus_b.req1 = 1'b0; bus_b.we1 = 1'b0; bus_b.addr1 = '0; bus_b.wdata1 = '0;

        // INIT_EN=0 instance: no grant during reset, immediate service after.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("b_rst_gnt0", 32'(bus_b.gnt0), 32'd0);
        check_val("b_rst_done", 32'(init_done_b), 32'd0);
        @(posedge clock); #1 reset_b = 1'b0;
        @(negedge clock);
        check_val("b_init_done", 32'(init_done_b), 32'd1);
        check_val("b_gnt0", 32'(bus_b.gnt0), 32'd1);
        check_val("b_gnt1", 32'(bus_b.gnt1), 32'd0);
        @(posedge clock); #1 bus_b.req0 = 1'b0;
        @(negedge clock);
        check_val("b_chip_en", 32'(bus_b.mem_chip_en), 32'd1);
        check_val("b_rd_en", 32'(bus_b.mem_rd_en), 32'd1);
        check_val("b_addr", 32'(bus_b.mem_addr), 32'h055);
        check_val("b_gnt0_idle", 32'(bus_b.gnt0), 32'd0);

        // Zero-fill sweep with a read held by port 0 the whole time.
        @(posedge clock); #1 mon_en = 1'b1;
        q0.push_back(mk(1'b0, 1'b0, 12'h005, 32'h0));
        @(posedge clock); #1 reset = 1'b0;
        wait_idle(5000);

        // Write then read back, plus a never-written neighbour.
        q0.push_back(mk(1'b0, 1'b1, 12'h3FF, 32'hDEADBEEF));
        q0.push_back(mk(1'b0, 1'b0, 12'h3FF, 32'h0));
        q0.push_back(mk(1'b0, 1'b0, 12'h400, 32'h0));
        wait_idle(100);

        // Round-robin: make port 1 the last winner, then sustained contention.
        q1.push_back(mk(1'b0, 1'b0, 12'h010, 32'h0));
        wait_idle(100);
        gnt_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 1'b0, 12'(i), 32'h0));
            q1.push_back(mk(1'b0, 1'b0, 12'(i + 8), 32'h0));
        end
        wait_idle(100);
        q0.push_back(mk(1'b0, 1'b0, 12'h020, 32'h0));
        q1.push_back(mk(1'b0, 1'b0, 12'h021, 32'h0));
        wait_idle(100);
        check_val("rr_len", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            check_val("rr_seq", 32'(gnt_log[i]), 32'(exp_seq[i]));

        // Port 1 read stream with a port 0 write slipped in between.
        q1.push_back(mk(1'b0, 1'b0, 12'h001, 32'h0));
        q1.push_back(mk(1'b0, 1'b0, 12'h002, 32'h0));
        q1.push_back(mk(1'b0, 1'b0, 12'h003, 32'h0));
        q0.push_back(mk(1'b1, 1'b0, 12'h000, 32'h0));
        q0.push_back(mk(1'b0, 1'b1, 12'h002, 32'h12345678));
        wait_idle(100);

        // Reset one cycle after a read grant: response must be dropped, INIT restarts.
        q0.push_back(mk(1'b0, 1'b0, 12'h3FF, 32'h0));
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            if (bus.gnt0) got = 1'b1;
        end
        check_val("rst_gnt_seen", 32'(got), 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        wait_idle(5000);

        // Random mixed traffic over a small address window to provoke hazards.
        for (int i = 0; i < 150; i++) begin
            q0.push_back(mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                            12'($urandom_range(0, 15)), $urandom));
            q1.push_back(mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                            12'($urandom_range(0, 15)), $urandom));
        end
        wait_idle(2000);

        repeat (4) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
